tw4_cmul_stage: RTL and testbench

- Pipelined complex twiddle multiplier for the radix-2^2 FFT stage.
- Consumes a streaming complex sample stream and produces one twisted sample per accepted input.
- Keeps a 2-bit sample-index counter that drives the address of the shared 4-entry twiddle ROM, mem_tw4 (Q1.7, 9-bit signed re/im).
- Multiplies each sample by the selected twiddle, then rounds, saturates and forwards the result with a valid/ready handshake.

---
 rtl/fft_pkg.sv | 40 ++++
 rtl/mem_tw4.sv | 31 +++
 rtl/tw4_cmul_stage.sv | 123 ++++++++++++
 tb/tb_tw4_cmul_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath types and helpers.
// Widths, complex sample type and the round/saturate step.
package fft_pkg;

  localparam int DW      = 16;
  localparam int TW_W    = 9;
  localparam int TW_FRAC = 7;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  localparam int SW = DW + TW_W + 2;

  localparam logic signed [SW-1:0] RND =
    {{(SW-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};
  localparam logic signed [SW-1:0] SMAX =
    {{(TW_W+3){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(TW_W+3){1'b1}}, {(DW-1){1'b0}}};

  // Half-up rounding drops TW_FRAC bits, then clamps to DW.
  function automatic logic signed [DW-1:0] sat_round(
    input logic signed [DW+TW_W:0] x
  );
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] s;
    t = SW'(x) + RND;
    s = t >>> TW_FRAC;
    if (s > SMAX) begin
      sat_round = SMAX[DW-1:0];
    end else if (s < SMIN) begin
      sat_round = SMIN[DW-1:0];
    end else begin
      sat_round = s[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/mem_tw4.sv
// Shared 4-entry twiddle ROM, Q1.7 signed re/im.
// Combinational read; indices 0..2 are 1+j0, index 3 is -j.
module mem_tw4 #(
  parameter int TW_W    = 9,
  parameter int TW_FRAC = 7
) (
  input  logic [1:0]             addr,
  output logic signed [TW_W-1:0] tw_re,
  output logic signed [TW_W-1:0] tw_im
);

  localparam logic signed [TW_W-1:0] ONE =
    {{(TW_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}} <<< 1;
  localparam logic signed [TW_W-1:0] NEG = -ONE;

  always_comb begin
    tw_re = ONE;
    tw_im = '0;
    unique case (1'b1)
      (addr == 2'd3): begin
        tw_re = '0;
        tw_im = NEG;
      end
      default: begin
        tw_re = ONE;
        tw_im = '0;
      end
    endcase
  end

endmodule

// File: rtl/tw4_cmul_stage.sv
// Radix-2^2 twiddle stage: 3-deep complex multiply pipeline
// with a sample-index counter addressing the shared ROM.
module tw4_cmul_stage #(
  parameter int DW      = 16,
  parameter int TW_W    = 9,
  parameter int TW_FRAC = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] din_re,
  input  logic signed [DW-1:0] din_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic [1:0]           out_idx,
  output logic signed [DW-1:0] dout_re,
  output logic signed [DW-1:0] dout_im
);

  import fft_pkg::cplx_t;
  import fft_pkg::sat_round;

  localparam int PW = DW + TW_W;

  logic                   advance;
  logic                   acc;
  logic [1:0]             cnt;
  logic [1:0]             idx_sel;
  logic signed [TW_W-1:0] rom_re;
  logic signed [TW_W-1:0] rom_im;

  logic                   v1;
  cplx_t                  s1_d;
  logic signed [TW_W-1:0] s1_twr;
  logic signed [TW_W-1:0] s1_twi;
  logic                   s1_sof;
  logic [1:0]             s1_idx;

  logic                   v2;
  logic signed [PW-1:0]   p_ac;
  logic signed [PW-1:0]   p_bd;
  logic signed [PW-1:0]   p_ad;
  logic signed [PW-1:0]   p_bc;
  logic                   s2_sof;
  logic [1:0]             s2_idx;

  logic                   v3;
  logic signed [PW:0]     sum_re;
  logic signed [PW:0]     sum_im;

  assign advance   = !v3 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3;

  always_comb begin
    acc     = in_valid && advance;
    idx_sel = in_sof ? 2'd0 : cnt;
    sum_re  = (PW+1)'(p_ac) - (PW+1)'(p_bd);
    sum_im  = (PW+1)'(p_ad) + (PW+1)'(p_bc);
  end

  mem_tw4 #(
    .TW_W    (TW_W),
    .TW_FRAC (TW_FRAC)
  ) u_rom (
    .addr  (idx_sel),
    .tw_re (rom_re),
    .tw_im (rom_im)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_d    <= '0;
      s1_twr  <= '0;
      s1_twi  <= '0;
      s1_sof  <= 1'b0;
      s1_idx  <= '0;
      p_ac    <= '0;
      p_bd    <= '0;
      p_ad    <= '0;
      p_bc    <= '0;
      s2_sof  <= 1'b0;
      s2_idx  <= '0;
      out_sof <= 1'b0;
      out_idx <= '0;
      dout_re <= '0;
      dout_im <= '0;
    end else begin
      if (acc) begin
        cnt <= idx_sel + 2'd1;
      end
      // Whole pipe moves in lockstep; bubbles ride along as !v.
      if (advance) begin
        v1      <= acc;
        s1_d    <= '{re: din_re, im: din_im};
        s1_twr  <= rom_re;
        s1_twi  <= rom_im;
        s1_sof  <= in_sof;
        s1_idx  <= idx_sel;
        v2      <= v1;
        p_ac    <= PW'(s1_d.re) * PW'(s1_twr);
        p_bd    <= PW'(s1_d.im) * PW'(s1_twi);
        p_ad    <= PW'(s1_d.re) * PW'(s1_twi);
        p_bc    <= PW'(s1_d.im) * PW'(s1_twr);
        s2_sof  <= s1_sof;
        s2_idx  <= s1_idx;
        v3      <= v2;
        out_sof <= s2_sof;
        out_idx <= s2_idx;
        dout_re <= sat_round(sum_re);
        dout_im <= sat_round(sum_im);
      end
    end
  end

endmodule

// File: tb/tb_tw4_cmul_stage.sv
// Scoreboard bench for tw4_cmul_stage.
// Driver pushes model results; monitor compares DUT output.
module tb_tw4_cmul_stage;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  logic signed [15:0] din_re;
  logic signed [15:0] din_im;
  logic               out_valid;
  logic               out_ready;
  logic               out_sof;
  logic [1:0]         out_idx;
  logic signed [15:0] dout_re;
  logic signed [15:0] dout_im;

  typedef struct {
    bit       sof;
    bit [1:0] idx;
    int       re;
    int       im;
    int       cyc;
    bit       lat;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   cnt  = 0;
  bit   lat_mode = 1'b1;

  tw4_cmul_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .din_re    (din_re),
    .din_im    (din_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_idx   (out_idx),
    .dout_re   (dout_re),
    .dout_im   (dout_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Q1.7 twiddles: 1, 1, 1, -j
  function automatic void tw(input int i, output longint c, output longint d);
    if (i == 3) begin
      c = 0;
      d = -128;
    end else begin
      c = 128;
      d = 0;
    end
  endfunction

  function automatic int rs(input longint x);
    longint y;
    longint r;
    y = x + 64;
    r = ((y % 128) + 128) % 128;
    y = (y - r) / 128;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return -16'sd32768;
      1: return 16'sd32767;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit sof,
                       input logic signed [15:0] a,
                       input logic signed [15:0] b, input bit ordy);
    exp_t e;
    longint c, d;
    @(negedge clk);
    rst = r;
    in_valid = v;
    in_sof = sof;
    din_re = a;
    din_im = b;
    out_ready = ordy;
    #2;
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (in_valid && in_ready) begin
      e.idx = sof ? 2'd0 : 2'(cnt);
      cnt = (int'(e.idx) + 1) % 4;
      tw(int'(e.idx), c, d);
      e.sof = sof;
      e.re = rs(longint'(a) * c - longint'(b) * d);
      e.im = rs(longint'(a) * d + longint'(b) * c);
      e.cyc = cyc;
      e.lat = lat_mode;
      q.push_back(e);
    end
  endtask

  // Output must match queue head whenever valid; pop on handshake.
  always begin
    @(negedge clk);
    #3;
    if (!rst && out_valid) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_out: got idx=%0d re=%0d im=%0d, want none",
                 out_idx, dout_re, dout_im);
      end else begin
        if (out_sof != q[0].sof || out_idx != q[0].idx ||
            int'(dout_re) != q[0].re || int'(dout_im) != q[0].im) begin
          nerr++;
          $display("FAIL out_sample: got sof=%0b idx=%0d re=%0d im=%0d, want sof=%0b idx=%0d re=%0d im=%0d",
                   out_sof, out_idx, dout_re, dout_im,
                   q[0].sof, q[0].idx, q[0].re, q[0].im);
        end
        if (q[0].lat) begin
          check("latency", cyc - q[0].cyc, 3);
          q[0].lat = 1'b0;
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    din_re = '0;
    din_im = '0;
    out_ready = 1'b1;

    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout_re", dout_re, 0);
    check("rst_dout_im", dout_im, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_sof", out_sof, 0);

    for (int i = 0; i < 8; i++) drive(0, 1, i == 0, 1000, -500, 1);
    idle(5);

    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 0, 1, 1, 1);
    drive(0, 1, 0, 2, 2, 1);
    drive(0, 1, 0, -16'sd32768, 0, 1);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 1, 0, 1, 1, 1);
    drive(0, 1, 0, 2, 2, 1);
    drive(0, 1, 0, 0, -16'sd32768, 1);
    idle(5);

    lat_mode = 1'b0;
    for (int i = 0; i < 5; i++) drive(0, 1, i == 0, rnd16(), rnd16(), 0);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) drive(0, 1, 0, rnd16(), rnd16(), 1);
    idle(5);
    lat_mode = 1'b1;

    drive(0, 1, 1, 300, 400, 1);
    drive(0, 1, 0, 301, 401, 1);
    drive(0, 1, 1, 302, 402, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 16'(-7 * i), 16'(9 * i), 1);
    idle(5);

    drive(0, 1, 1, 10, 20, 1);
    drive(0, 1, 0, 11, 21, 1);
    drive(0, 1, 0, 12, 22, 1);
    drive(1, 1, 0, 13, 23, 1);
    drive(0, 0, 0, 0, 0, 1);
    check("post_rst_valid", out_valid, 0);
    drive(0, 1, 0, -1234, 5678, 1);
    drive(0, 1, 0, 4321, -8765, 1);
    idle(5);

    for (int i = 0; i < 8; i++) drive(0, (i % 2) == 0, i == 0, rnd16(), rnd16(), 1);
    idle(5);

    lat_mode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            rnd16(), rnd16(), $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) drive(0, 0, 0, 0, 0, 1);
    check("drain_left", q.size(), 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
